// File: rtl/pc_gen_pkg.sv
// Shared constants for the program-counter generator: pc_src encodings and
// default vector addresses.
package pc_gen_pkg;

  localparam logic [2:0] SRC_SEQ    = 3'b000;
  localparam logic [2:0] SRC_BRANCH = 3'b001;
  localparam logic [2:0] SRC_JUMP   = 3'b010;
  localparam logic [2:0] SRC_JR     = 3'b011;
  localparam logic [2:0] SRC_ILLOP  = 3'b100;
  localparam logic [2:0] SRC_XADR   = 3'b101;
  localparam logic [2:0] SRC_ERET   = 3'b110;
  localparam logic [2:0] SRC_HOLD   = 3'b111;

  localparam logic [31:0] DEF_RESET_PC = 32'h8000_0000;
  localparam logic [31:0] DEF_ILLOP_PC = 32'h8000_0004;
  localparam logic [31:0] DEF_XADR_PC  = 32'h8000_0008;

endpackage

// File: rtl/pc_gen_if.sv
// Control/observation bundle between the fetch controller and pc_gen.
// No valid/ready handshake: every control input is sampled on each rising
// edge where stall=0, and every output reflects the current registered state.
interface pc_gen_if;
  logic        stall;
  logic [2:0]  pc_src;
  logic        br_taken;
  logic [31:0] ext_imm;
  logic [25:0] jt;
  logic [31:0] jr_addr;
  logic        link;
  logic        ret_hint;
  logic [31:0] pc;
  logic [31:0] plus4;
  logic [31:0] epc;
  logic        kmode;
  logic [31:0] ras_top;
  logic        ras_valid;

  modport master (
    output stall, pc_src, br_taken, ext_imm, jt, jr_addr, link, ret_hint,
    input  pc, plus4, epc, kmode, ras_top, ras_valid
  );

  modport slave (
    input  stall, pc_src, br_taken, ext_imm, jt, jr_addr, link, ret_hint,
    output pc, plus4, epc, kmode, ras_top, ras_valid
  );
endinterface

// File: rtl/pc_ras.sv
// Return-address stack: circular buffer where a push into a full stack
// overwrites the oldest entry, and a pop of an empty stack is ignored.
module pc_ras #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  logic [31:0] wdata,
  output logic [31:0] top,
  output logic        valid
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] wp;
  logic [CW-1:0] count;

  // wp names the next free slot, so the top entry always sits just below it.
  assign valid = (count != '0);
  assign top   = valid ? mem[wp - PW'(1)] : 32'h0;

  always_ff @(posedge clk) begin
    if (reset) begin
      wp    <= '0;
      count <= '0;
    end else if (push) begin
      mem[wp] <= wdata;
      wp      <= wp + PW'(1);
      if (count != CW'(DEPTH)) count <= count + CW'(1);
    end else if (pop && valid) begin
      wp    <= wp - PW'(1);
      count <= count - CW'(1);
    end
  end
endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: target computation, next-PC selection,
// exception PC capture and return-address-stack prediction.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
  parameter logic [31:0] ILLOP_PC  = DEF_ILLOP_PC,
  parameter logic [31:0] XADR_PC   = DEF_XADR_PC,
  parameter int          RAS_DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset,
  pc_gen_if.slave  bus
);
  logic [31:0] pc_q, epc_q, pc_nxt, epc_nxt;
  logic [31:0] plus4, br_tgt, j_tgt;
  logic        kmode, push, pop;
  logic        unused_imm_hi;

  // The kernel bit is preserved across sequential increment.
  assign plus4  = {pc_q[31], pc_q[30:0] + 31'd4};
  assign br_tgt = plus4 + {bus.ext_imm[29:0], 2'b00};
  assign j_tgt  = {pc_q[31:28], bus.jt, 2'b00};
  assign kmode  = pc_q[31];
  assign unused_imm_hi = ^bus.ext_imm[31:30];

  always_comb begin
    pc_nxt  = pc_q;
    epc_nxt = epc_q;
    push    = 1'b0;
    pop     = 1'b0;
    if (!bus.stall) begin
      case (bus.pc_src)
        SRC_SEQ:    pc_nxt = plus4;
        SRC_BRANCH: pc_nxt = bus.br_taken ? br_tgt : plus4;
        SRC_JUMP: begin
          pc_nxt = j_tgt;
          push   = bus.link;
        end
        SRC_JR: begin
          pc_nxt = bus.jr_addr;
          pop    = bus.ret_hint;
        end
        SRC_ILLOP: begin
          pc_nxt  = ILLOP_PC;
          epc_nxt = pc_q;
        end
        // Interrupts are masked in kernel mode and fall through as sequential.
        SRC_XADR: begin
          if (kmode) begin
            pc_nxt = plus4;
          end else begin
            pc_nxt  = XADR_PC;
            epc_nxt = pc_q;
          end
        end
        SRC_ERET: pc_nxt = {1'b0, epc_q[30:0]};
        SRC_HOLD: pc_nxt = pc_q;
        default:  pc_nxt = pc_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= RESET_PC;
      epc_q <= 32'h0;
    end else begin
      pc_q  <= pc_nxt;
      epc_q <= epc_nxt;
    end
  end

  pc_ras #(.DEPTH(RAS_DEPTH)) u_ras (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (plus4),
    .top   (bus.ras_top),
    .valid (bus.ras_valid)
  );

  assign bus.pc    = pc_q;
  assign bus.plus4 = plus4;
  assign bus.epc   = epc_q;
  assign bus.kmode = kmode;
endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus randomized traffic
// compared against a behavioural model using a queue for the return stack.
module tb_pc_gen;
  localparam logic [31:0] RESET_PC  = 32'h8000_0000;
  localparam logic [31:0] ILLOP_PC  = 32'h8000_0004;
  localparam logic [31:0] XADR_PC   = 32'h8000_0008;
  localparam int          RAS_DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  logic [31:0] m_pc, m_epc;
  logic [31:0] m_ras[$];

  pc_gen_if bus();

  pc_gen #(
    .RESET_PC (RESET_PC),
    .ILLOP_PC (ILLOP_PC),
    .XADR_PC  (XADR_PC),
    .RAS_DEPTH(RAS_DEPTH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Model of one clock edge, computed directly from the architectural rules.
  task automatic model_edge(input logic rst, input logic stl, input logic [2:0] src,
                            input logic br, input logic [31:0] imm, input logic [25:0] jt,
                            input logic [31:0] jra, input logic lnk, input logic ret);
    logic [31:0] p4;
    if (rst) begin
      m_pc  = RESET_PC;
      m_epc = 32'h0;
      m_ras.delete();
    end else if (!stl) begin
      p4 = (m_pc & 32'h8000_0000) | ((m_pc + 32'd4) & 32'h7FFF_FFFF);
      case (src)
        3'd0: m_pc = p4;
        3'd1: m_pc = br ? p4 + (imm << 2) : p4;
        3'd2: begin
          if (lnk) begin
            if (m_ras.size() == RAS_DEPTH) void'(m_ras.pop_front());
            m_ras.push_back(p4);
          end
          m_pc = {m_pc[31:28], jt, 2'b00};
        end
        3'd3: begin
          if (ret && m_ras.size() > 0) void'(m_ras.pop_back());
          m_pc = jra;
        end
        3'd4: begin m_epc = m_pc; m_pc = ILLOP_PC; end
        3'd5: begin
          if (m_pc[31]) m_pc = p4;
          else begin m_epc = m_pc; m_pc = XADR_PC; end
        end
        3'd6: m_pc = m_epc & 32'h7FFF_FFFF;
        default: m_pc = m_pc;
      endcase
    end
  endtask

  task automatic compare_all();
    logic [31:0] exp_top;
    exp_top = (m_ras.size() > 0) ? m_ras[m_ras.size()-1] : 32'h0;
    check_eq("pc", bus.pc, m_pc);
    check_eq("epc", bus.epc, m_epc);
    check_eq("plus4", bus.plus4, (m_pc & 32'h8000_0000) | ((m_pc + 32'd4) & 32'h7FFF_FFFF));
    check_eq("kmode", {31'h0, bus.kmode}, {31'h0, m_pc[31]});
    check_eq("ras_top", bus.ras_top, exp_top);
    check_eq("ras_valid", {31'h0, bus.ras_valid}, (m_ras.size() > 0) ? 32'd1 : 32'd0);
  endtask

  // Drive one cycle of inputs, advance the model with the edge, then compare.
  task automatic step(input logic rst, input logic stl, input logic [2:0] src,
                      input logic br, input logic [31:0] imm, input logic [25:0] jt,
                      input logic [31:0] jra, input logic lnk, input logic ret);
    reset        = rst;
    bus.stall    = stl;
    bus.pc_src   = src;
    bus.br_taken = br;
    bus.ext_imm  = imm;
    bus.jt       = jt;
    bus.jr_addr  = jra;
    bus.link     = lnk;
    bus.ret_hint = ret;
    @(posedge clk);
    model_edge(rst, stl, src, br, imm, jt, jra, lnk, ret);
    #1;
    compare_all();
  endtask

  task automatic simple(input logic [2:0] src);
    step(1'b0, 1'b0, src, 1'b0, 32'h0, 26'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic goto(input logic [31:0] addr);
    step(1'b0, 1'b0, 3'd3, 1'b0, 32'h0, 26'h0, addr, 1'b0, 1'b0);
  endtask

  logic [31:0] save_pc, save_epc, save_top;
  logic        save_valid;

  initial begin
    m_pc  = 32'h0;
    m_epc = 32'h0;
    @(negedge clk);

    // Reset wins over stall and a pending interrupt.
    step(1'b1, 1'b1, 3'd5, 1'b0, 32'h0, 26'h0, 32'h0, 1'b0, 1'b0);
    check_eq("rst_pc", bus.pc, 32'h8000_0000);
    check_eq("rst_epc", bus.epc, 32'h0);
    check_eq("rst_ras_valid", {31'h0, bus.ras_valid}, 32'h0);
    check_eq("rst_ras_top", bus.ras_top, 32'h0);

    simple(3'd0); check_eq("seq1", bus.pc, 32'h8000_0004);
    simple(3'd0); check_eq("seq2", bus.pc, 32'h8000_0008);
    simple(3'd0); check_eq("seq3", bus.pc, 32'h8000_000C);

    goto(32'h0000_0100);
    step(1'b0, 1'b0, 3'd1, 1'b1, 32'hFFFF_FFFE, 26'h0, 32'h0, 1'b0, 1'b0);
    check_eq("br_taken", bus.pc, 32'h0000_00FC);
    goto(32'h0000_0100);
    step(1'b0, 1'b0, 3'd1, 1'b0, 32'hFFFF_FFFE, 26'h0, 32'h0, 1'b0, 1'b0);
    check_eq("br_not_taken", bus.pc, 32'h0000_0104);

    goto(32'h0000_0040);
    simple(3'd5);
    check_eq("xadr_pc", bus.pc, 32'h8000_0008);
    check_eq("xadr_epc", bus.epc, 32'h0000_0040);
    simple(3'd5);
    check_eq("xadr_masked_pc", bus.pc, 32'h8000_000C);
    check_eq("xadr_masked_epc", bus.epc, 32'h0000_0040);
    simple(3'd6);
    check_eq("eret_pc", bus.pc, 32'h0000_0040);

    // Five linked jumps into a four-deep stack; the first entry is lost.
    goto(32'h0000_0010);
    for (int i = 0; i < 5; i++) begin
      logic [31:0] tgt;
      tgt = 32'h20 + 32'h10 * i;
      step(1'b0, 1'b0, 3'd2, 1'b0, 32'h0, tgt[27:2], 32'h0, 1'b1, 1'b0);
    end
    check_eq("ras_full_top", bus.ras_top, 32'h0000_0054);
    step(1'b0, 1'b0, 3'd3, 1'b0, 32'h0, 26'h0, 32'h200, 1'b0, 1'b1);
    check_eq("pop1_top", bus.ras_top, 32'h0000_0044);
    check_eq("pop1_pc", bus.pc, 32'h0000_0200);
    step(1'b0, 1'b0, 3'd3, 1'b0, 32'h0, 26'h0, 32'h200, 1'b0, 1'b1);
    check_eq("pop2_top", bus.ras_top, 32'h0000_0034);
    step(1'b0, 1'b0, 3'd3, 1'b0, 32'h0, 26'h0, 32'h200, 1'b0, 1'b1);
    check_eq("pop3_top", bus.ras_top, 32'h0000_0024);
    check_eq("pop3_valid", {31'h0, bus.ras_valid}, 32'h1);
    step(1'b0, 1'b0, 3'd3, 1'b0, 32'h0, 26'h0, 32'h200, 1'b0, 1'b1);
    check_eq("pop4_valid", {31'h0, bus.ras_valid}, 32'h0);
    step(1'b0, 1'b0, 3'd3, 1'b0, 32'h0, 26'h0, 32'h200, 1'b0, 1'b1);
    check_eq("pop_empty_valid", {31'h0, bus.ras_valid}, 32'h0);
    check_eq("pop_empty_top", bus.ras_top, 32'h0);

    // Stall freezes everything, then the held illop is taken on release.
    goto(32'h0000_0300);
    step(1'b0, 1'b0, 3'd2, 1'b0, 32'h0, 26'h0C1, 32'h0, 1'b1, 1'b0);
    save_pc = bus.pc; save_epc = bus.epc; save_top = bus.ras_top; save_valid = bus.ras_valid;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 3'd4, 1'b0, 32'h0, 26'h0, 32'h0, 1'b1, 1'b1);
      check_eq("stall_pc", bus.pc, save_pc);
      check_eq("stall_epc", bus.epc, save_epc);
      check_eq("stall_ras_top", bus.ras_top, save_top);
      check_eq("stall_ras_valid", {31'h0, bus.ras_valid}, {31'h0, save_valid});
    end
    simple(3'd4);
    check_eq("illop_pc", bus.pc, ILLOP_PC);
    check_eq("illop_epc", bus.epc, save_pc);

    for (int n = 0; n < 400; n++) begin
      logic [31:0] jra;
      jra = $urandom;
      if ($urandom_range(0, 3) == 0) jra[31] = 1'b0;
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) == 0),
           3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom,
           26'($urandom), jra, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
